// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT widths, lane selector type and lane rotation rule
package fft_pkg;

  localparam int BIT_DEFAULT = 17;
  localparam int LANES       = 4;

  typedef logic [1:0] selT;

  // Input mixer places Xk on lane (k + sel) mod 4; the output mixer reads it back from there.
  function automatic logic [1:0] rotLane(input logic [1:0] k, input selT sel);
    return k + sel;
  endfunction

  function automatic logic [1:0] srcLane(input logic [1:0] j, input selT sel);
    return j - sel;
  endfunction

endpackage

// File: rtl/fft_lane_rotate.sv
// rtl/fft_lane_rotate.sv - combinational 4-lane rotator, Y[(k+sel) mod 4] = Xk
module fft_lane_rotate
  import fft_pkg::*;
#(
  parameter int W = 2 * BIT_DEFAULT
) (
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  input  selT          sel,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3
);

  logic [W-1:0] xLane [LANES];
  logic [W-1:0] yLane [LANES];

  assign xLane[0] = x0;
  assign xLane[1] = x1;
  assign xLane[2] = x2;
  assign xLane[3] = x3;

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      yLane[j] = xLane[srcLane(2'(j), sel)];
    end
  end

  assign y0 = yLane[0];
  assign y1 = yLane[1];
  assign y2 = yLane[2];
  assign y3 = yLane[3];

endmodule

// File: rtl/fft_input_mix.sv
// rtl/fft_input_mix.sv - gathers serial complex samples into groups of four and rotates them across lanes
module fft_input_mix
  import fft_pkg::*;
#(
  parameter int BIT = BIT_DEFAULT
) (
  input  logic           iCLK,
  input  logic           iRESET,
  input  logic           iVALID,
  input  logic           iSYNC,
  input  logic [1:0]     iSEL,
  input  logic [BIT-1:0] iRE,
  input  logic [BIT-1:0] iIM,
  output logic [BIT-1:0] oY0_RE,
  output logic [BIT-1:0] oY0_IM,
  output logic [BIT-1:0] oY1_RE,
  output logic [BIT-1:0] oY1_IM,
  output logic [BIT-1:0] oY2_RE,
  output logic [BIT-1:0] oY2_IM,
  output logic [BIT-1:0] oY3_RE,
  output logic [BIT-1:0] oY3_IM,
  output logic           oVALID,
  output logic [1:0]     oSLOT
);

  logic [1:0]     slotQ;
  logic [1:0]     effSlot;
  selT            selQ;
  logic [BIT-1:0] stageRe [3];
  logic [BIT-1:0] stageIm [3];
  logic [2*BIT-1:0] rotY0, rotY1, rotY2, rotY3;

  // A sync pulse alongside a valid sample restarts the group with that sample.
  assign effSlot = iSYNC ? 2'd0 : slotQ;

  // X3 bypasses staging so the group can complete on the same edge it arrives.
  fft_lane_rotate #(
    .W (2 * BIT)
  ) uRotate (
    .x0  ({stageRe[0], stageIm[0]}),
    .x1  ({stageRe[1], stageIm[1]}),
    .x2  ({stageRe[2], stageIm[2]}),
    .x3  ({iRE, iIM}),
    .sel (selQ),
    .y0  (rotY0),
    .y1  (rotY1),
    .y2  (rotY2),
    .y3  (rotY3)
  );

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      slotQ  <= 2'd0;
      selQ   <= 2'd0;
      oVALID <= 1'b0;
      oY0_RE <= '0;
      oY0_IM <= '0;
      oY1_RE <= '0;
      oY1_IM <= '0;
      oY2_RE <= '0;
      oY2_IM <= '0;
      oY3_RE <= '0;
      oY3_IM <= '0;
      for (int i = 0; i < 3; i++) begin
        stageRe[i] <= '0;
        stageIm[i] <= '0;
      end
    end else begin
      oVALID <= 1'b0;
      if (iVALID) begin
        if (effSlot == 2'd0) begin
          selQ <= iSEL;
        end
        case (effSlot)
          2'd0: begin
            stageRe[0] <= iRE;
            stageIm[0] <= iIM;
          end
          2'd1: begin
            stageRe[1] <= iRE;
            stageIm[1] <= iIM;
          end
          2'd2: begin
            stageRe[2] <= iRE;
            stageIm[2] <= iIM;
          end
          default: begin
            {oY0_RE, oY0_IM} <= rotY0;
            {oY1_RE, oY1_IM} <= rotY1;
            {oY2_RE, oY2_IM} <= rotY2;
            {oY3_RE, oY3_IM} <= rotY3;
            oVALID           <= 1'b1;
          end
        endcase
        slotQ <= effSlot + 2'd1;
      end else if (iSYNC) begin
        slotQ <= 2'd0;
      end
    end
  end

  assign oSLOT = slotQ;

endmodule

// File: tb/tb_fft_input_mix.sv
// tb/tb_fft_input_mix.sv - directed self-checking bench for fft_input_mix
module tb_fft_input_mix;

  localparam int BIT = 17;

  logic                  iCLK = 1'b0;
  logic                  iRESET;
  logic                  iVALID;
  logic                  iSYNC;
  logic [1:0]            iSEL;
  logic signed [BIT-1:0] iRE;
  logic signed [BIT-1:0] iIM;
  logic signed [BIT-1:0] oY0_RE, oY0_IM, oY1_RE, oY1_IM;
  logic signed [BIT-1:0] oY2_RE, oY2_IM, oY3_RE, oY3_IM;
  logic                  oVALID;
  logic [1:0]            oSLOT;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  // Rows are sel, columns are output lanes, entries are which Xk lands there.
  int rotIdx [4][4] = '{'{0, 1, 2, 3}, '{3, 0, 1, 2}, '{2, 3, 0, 1}, '{1, 2, 3, 0}};

  fft_input_mix #(.BIT(BIT)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iVALID (iVALID),
    .iSYNC  (iSYNC),
    .iSEL   (iSEL),
    .iRE    (iRE),
    .iIM    (iIM),
    .oY0_RE (oY0_RE),
    .oY0_IM (oY0_IM),
    .oY1_RE (oY1_RE),
    .oY1_IM (oY1_IM),
    .oY2_RE (oY2_RE),
    .oY2_IM (oY2_IM),
    .oY3_RE (oY3_RE),
    .oY3_IM (oY3_IM),
    .oVALID (oVALID),
    .oSLOT  (oSLOT)
  );

  always #5 iCLK = ~iCLK;

  always @(negedge iCLK) begin
    if (oVALID === 1'b1) pulses++;
  end

  task automatic checkVal(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic [1:0] sel,
                      input int re, input int im);
    @(negedge iCLK);
    iRESET = r;
    iVALID = v;
    iSYNC  = s;
    iSEL   = sel;
    iRE    = re[BIT-1:0];
    iIM    = im[BIT-1:0];
    @(posedge iCLK);
    #1;
  endtask

  function automatic logic signed [31:0] yRe(input int j);
    case (j)
      0:       return 32'(oY0_RE);
      1:       return 32'(oY1_RE);
      2:       return 32'(oY2_RE);
      default: return 32'(oY3_RE);
    endcase
  endfunction

  function automatic logic signed [31:0] yIm(input int j);
    case (j)
      0:       return 32'(oY0_IM);
      1:       return 32'(oY1_IM);
      2:       return 32'(oY2_IM);
      default: return 32'(oY3_IM);
    endcase
  endfunction

  task automatic checkGroup(input string tag, input int re [4], input int im [4]);
    checkVal({tag, "_valid"}, 32'(oVALID), 1);
    for (int j = 0; j < 4; j++) begin
      checkVal($sformatf("%s_re%0d", tag, j), yRe(j), re[j]);
      checkVal($sformatf("%s_im%0d", tag, j), yIm(j), im[j]);
    end
  endtask

  initial begin
    int expRe [4];
    int expIm [4];
    int back  [4];

    iRESET = 1'b1;
    iVALID = 1'b0;
    iSYNC  = 1'b0;
    iSEL   = 2'd0;
    iRE    = '0;
    iIM    = '0;

    // Reset dominates random activity on every input.
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), int'($urandom), int'($urandom));
      checkVal("rst_valid", 32'(oVALID), 0);
      checkVal("rst_slot", 32'(oSLOT), 0);
      checkVal("rst_y0re", yRe(0), 0);
      checkVal("rst_y3im", yIm(3), 0);
    end

    // Identity group.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'd0, k + 1, -(k + 1));
      if (k < 3) checkVal("id_slot", 32'(oSLOT), k + 1);
    end
    expRe = '{1, 2, 3, 4};
    expIm = '{-1, -2, -3, -4};
    checkGroup("ident", expRe, expIm);
    checkVal("id_slot_wrap", 32'(oSLOT), 0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 0, 0);
    checkVal("id_drop", 32'(oVALID), 0);
    checkVal("id_hold", yRe(3), 4);

    // Four back-to-back groups, one per selector, then undo with the output mixer.
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b0, 1'b1, 1'b0, 2'(s), 10 + k, 20 + k);
      end
      for (int j = 0; j < 4; j++) begin
        expRe[j] = 10 + rotIdx[s][j];
        expIm[j] = 20 + rotIdx[s][j];
      end
      checkGroup($sformatf("rot%0d", s), expRe, expIm);
      for (int k = 0; k < 4; k++) begin
        back[k] = int'(yRe((k + s) % 4));
        checkVal($sformatf("unmix%0d_x%0d", s, k), back[k], 10 + k);
      end
    end

    // Sparse valids and a selector change after slot 0.
    step(1'b0, 1'b0, 1'b0, 2'd0, 0, 0);
    p0 = pulses;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, (k == 0) ? 2'd1 : 2'd2, 30 + k, 40 + k);
      if (k < 3) begin
        for (int g = 0; g < 2; g++) begin
          step(1'b0, 1'b0, 1'b0, 2'd2, 99, 99);
          checkVal("gap_novalid", 32'(oVALID), 0);
          checkVal("gap_slot", 32'(oSLOT), k + 1);
        end
      end
    end
    expRe = '{33, 30, 31, 32};
    expIm = '{43, 40, 41, 42};
    checkGroup("gap", expRe, expIm);
    step(1'b0, 1'b0, 1'b0, 2'd0, 0, 0);
    checkVal("gap_pulses", pulses - p0, 1);

    // Resync with a valid sample drops the partial pair.
    p0 = pulses;
    step(1'b0, 1'b1, 1'b0, 2'd3, 50, 60);
    step(1'b0, 1'b1, 1'b0, 2'd3, 51, 61);
    step(1'b0, 1'b1, 1'b1, 2'd0, 100, 200);
    checkVal("sync_slot", 32'(oSLOT), 1);
    for (int k = 1; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'd3, 100 + k, 200 + k);
    end
    expRe = '{100, 101, 102, 103};
    expIm = '{200, 201, 202, 203};
    checkGroup("sync", expRe, expIm);
    step(1'b0, 1'b0, 1'b0, 2'd0, 0, 0);
    checkVal("sync_pulses", pulses - p0, 1);

    // Resync without a sample just clears the counter.
    step(1'b0, 1'b1, 1'b0, 2'd0, 7, 7);
    step(1'b0, 1'b0, 1'b1, 2'd0, 0, 0);
    checkVal("sync_idle_slot", 32'(oSLOT), 0);

    // Mid-group reset, then full-scale values.
    p0 = pulses;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'd0, 5, 5);
    end
    step(1'b1, 1'b1, 1'b0, 2'd0, 5, 5);
    checkVal("mrst_slot", 32'(oSLOT), 0);
    checkVal("mrst_valid", 32'(oVALID), 0);
    checkVal("mrst_y0re", yRe(0), 0);
    expRe = '{-65536, 65535, -65536, 65535};
    expIm = '{65535, -65536, 65535, -65536};
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 2'd0, expRe[k], expIm[k]);
    end
    checkGroup("ext", expRe, expIm);
    step(1'b0, 1'b0, 1'b0, 2'd0, 0, 0);
    checkVal("ext_pulses", pulses - p0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
